// File: rtl/core_mem_responder_pkg.sv
// ============================================================================
// core_mem_responder_pkg : shared state encoding and widths | rev 1.0
// ============================================================================
`default_nettype none

package core_mem_responder_pkg;

    localparam int c_BE_WIDTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_D_REQ  = 3'd1,
        ST_D_WAIT = 3'd2,
        ST_I_REQ  = 3'd3,
        ST_I_WAIT = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // IDLE and DONE are the only states in which the core may advance.
    function automatic logic is_busy(input state_t s);
        return !((s == ST_IDLE) || (s == ST_DONE));
    endfunction

endpackage

`default_nettype wire

// File: rtl/core_mem_responder_if.sv
// ============================================================================
// core_mem_responder_if : backing-memory valid/ready request and response bus | rev 1.0
// ============================================================================
`default_nettype none

interface core_mem_responder_if
    import core_mem_responder_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) ();

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [AWIDTH-1:0]     mem_req_addr;
    logic [c_BE_WIDTH-1:0] mem_req_we;
    logic [DWIDTH-1:0]     mem_req_wdata;
    logic                  mem_resp_valid;
    logic [DWIDTH-1:0]     mem_resp_data;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );

endinterface

`default_nettype wire

// File: rtl/core_mem_responder_sat_counter32.sv
// ============================================================================
// sat_counter32 : 32-bit enable counter, saturating at all-ones | rev 1.0
// ============================================================================
`default_nettype none

module sat_counter32 (
    input  wire logic        clk,
    input  wire logic        clr_n,
    input  wire logic        en,
    output logic      [31:0] count
);

    logic [31:0] r_count;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_count <= '0;
        end else if (en && (r_count != 32'hFFFF_FFFF)) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/core_mem_responder.sv
// ============================================================================
// core_mem_responder : serialises core icache/dcache requests onto one memory | rev 1.0
// ============================================================================
`default_nettype none

module core_mem_responder
    import core_mem_responder_pkg::*;
#(
    parameter int AWIDTH     = 32,
    parameter int DWIDTH     = 32,
    parameter bit WORD_ALIGN = 1'b1
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic [AWIDTH-1:0]     icache_addr,
    input  wire logic                  icache_re,
    output logic      [DWIDTH-1:0]     icache_dout,
    input  wire logic [AWIDTH-1:0]     dcache_addr,
    input  wire logic                  dcache_re,
    input  wire logic [c_BE_WIDTH-1:0] dcache_we,
    input  wire logic [DWIDTH-1:0]     dcache_din,
    output logic      [DWIDTH-1:0]     dcache_dout,
    output logic                       stall,
    core_mem_responder_if.master       mem,
    output logic      [31:0]           stall_cycles
);

    localparam logic [AWIDTH-1:0] c_ALIGN_MASK =
        WORD_ALIGN ? {{(AWIDTH-2){1'b1}}, 2'b00} : {AWIDTH{1'b1}};

    state_t                r_state;
    state_t                w_next;
    logic [AWIDTH-1:0]     r_iaddr;
    logic [AWIDTH-1:0]     r_daddr;
    logic [DWIDTH-1:0]     r_din;
    logic [c_BE_WIDTH-1:0] r_we;
    logic                  r_i_pend;
    logic                  r_d_pend;
    logic [DWIDTH-1:0]     r_idout;
    logic [DWIDTH-1:0]     r_ddout;
    logic                  w_capture;
    logic                  w_d_req_in;
    logic                  w_req_valid;
    logic [AWIDTH-1:0]     w_addr_sel;
    logic [c_BE_WIDTH-1:0] w_req_we;
    logic [DWIDTH-1:0]     w_req_wdata;

    assign w_capture  = !is_busy(r_state);
    assign w_d_req_in = dcache_re | (|dcache_we);
    assign stall      = is_busy(r_state);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Data access is always serviced before the instruction fetch.
    always_comb begin
        w_next      = r_state;
        w_req_valid = 1'b0;
        w_addr_sel  = '0;
        w_req_we    = '0;
        w_req_wdata = '0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_d_req_in)     w_next = ST_D_REQ;
                else if (icache_re) w_next = ST_I_REQ;
                else                w_next = ST_IDLE;
            end
            ST_D_REQ: begin
                w_req_valid = 1'b1;
                w_addr_sel  = r_daddr;
                w_req_we    = r_we;
                w_req_wdata = r_din;
                if (mem.mem_req_ready) w_next = ST_D_WAIT;
            end
            ST_D_WAIT: begin
                if (mem.mem_resp_valid) w_next = r_i_pend ? ST_I_REQ : ST_DONE;
            end
            ST_I_REQ: begin
                w_req_valid = 1'b1;
                w_addr_sel  = r_iaddr;
                if (mem.mem_req_ready) w_next = ST_I_WAIT;
            end
            ST_I_WAIT: begin
                if (mem.mem_resp_valid) w_next = ST_DONE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_iaddr  <= '0;
            r_daddr  <= '0;
            r_din    <= '0;
            r_we     <= '0;
            r_i_pend <= 1'b0;
            r_d_pend <= 1'b0;
            r_idout  <= '0;
            r_ddout  <= '0;
        end else begin
            if (w_capture) begin
                r_iaddr  <= icache_addr;
                r_daddr  <= dcache_addr;
                r_din    <= dcache_din;
                r_we     <= dcache_we;
                r_i_pend <= icache_re;
                r_d_pend <= w_d_req_in;
            end
            // Write acks carry no data, so only a read response touches dcache_dout.
            if ((r_state == ST_D_WAIT) && mem.mem_resp_valid && r_d_pend && (r_we == '0)) begin
                r_ddout <= mem.mem_resp_data;
            end
            if ((r_state == ST_I_WAIT) && mem.mem_resp_valid) begin
                r_idout <= mem.mem_resp_data;
            end
        end
    end

    assign mem.mem_req_valid = w_req_valid;
    assign mem.mem_req_addr  = w_addr_sel & c_ALIGN_MASK;
    assign mem.mem_req_we    = w_req_we;
    assign mem.mem_req_wdata = w_req_wdata;
    assign icache_dout       = r_idout;
    assign dcache_dout       = r_ddout;

    sat_counter32 u_stall_cnt (
        .clk   (clk),
        .clr_n (reset),
        .en    (stall),
        .count (stall_cycles)
    );

endmodule

`default_nettype wire
